param_bus_arbiter: RTL and testbench

Parametrised arbiter for the synth parameter register bus. It serialises accesses from REQS independent masters onto the single bank/address/data bus that feeds the envelope, oscillator, matrix and common parameter banks in synth_engine; typical masters are the CPU slave port, the sysex decoder and the socmidi path. It is the generalised successor to the fixed two-master CPU/sysex address mux. It adds N masters, round-robin fairness, per-master read-response routing, configurable read latency, and out-of-range bank error reporting.

---
 rtl/param_bus_arbiter_pkg.sv | 13 +
 rtl/param_bus_arbiter_rr_picker.sv | 36 +++
 rtl/param_bus_arbiter.sv | 89 ++++++++
 tb/tb_param_bus_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/param_bus_arbiter_pkg.sv
// param_bus_arbiter_pkg: FSM state type and sizing/decode helpers for the parameter bus arbiter
package param_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic logic [31:0] bank_onehot(input int unsigned b);
    return 32'd1 << b;
  endfunction
endpackage

// File: rtl/param_bus_arbiter_rr_picker.sv
// rr_picker: winner selection; round-robin from last winner + 1 when PARAM_ARB_RR_EN is defined,
// lowest-index fixed priority otherwise.
module rr_picker import param_bus_arbiter_pkg::*; #(
  parameter int REQS = 3,
  parameter int IDX_W = clogb2(REQS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQS-1:0]  req,
  input  logic             upd,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any
);
  assign any = |req;
`ifdef PARAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= IDX_W'(REQS - 1);
    else if (upd) ptr <= last;
  // Walk from farthest to nearest so the master right after ptr ends up winning.
  always_comb begin
    pick = '0;
    for (int k = REQS; k >= 1; k--)
      if (req[(int'(ptr) + k) % REQS]) pick = IDX_W'((int'(ptr) + k) % REQS);
  end
`else
  logic unused;
  assign unused = ^{clk, rst, upd, last};
  always_comb begin
    pick = '0;
    for (int k = REQS - 1; k >= 0; k--)
      if (req[k]) pick = IDX_W'(k);
  end
`endif
endmodule

// File: rtl/param_bus_arbiter.sv
// param_bus_arbiter: serialises REQS masters onto the synth parameter register bus.
// Define PARAM_ARB_RR_EN for round-robin arbitration; the default build is fixed priority.
module param_bus_arbiter import param_bus_arbiter_pkg::*; #(
  parameter int REQS   = 3,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int BANKS  = 6,
  parameter int BANK_W = clogb2(BANKS),
  parameter int RD_LAT = 1
) (
  input  logic                   reg_clk,
  input  logic                   reset_reg,
  input  logic [REQS-1:0]        req_valid,
  input  logic [REQS-1:0]        req_write,
  input  logic [REQS*BANK_W-1:0] req_bank,
  input  logic [REQS*ADDR_W-1:0] req_addr,
  input  logic [REQS*DATA_W-1:0] req_wdata,
  output logic [REQS-1:0]        req_ack,
  output logic [REQS-1:0]        rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [BANKS-1:0]       bus_sel,
  output logic [ADDR_W-1:0]      bus_adr,
  output logic [DATA_W-1:0]      bus_wdata,
  output logic                   bus_write,
  output logic                   bus_read,
  input  logic [DATA_W-1:0]      bus_rdata
);
  localparam int IDX_W = clogb2(REQS);
  localparam int CNT_W = clogb2(RD_LAT + 1);
  arb_state_t state, next;
  logic [IDX_W-1:0] pick, win;
  logic any, wr, bad, issue, go;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [CNT_W-1:0] cnt;
  rr_picker #(.REQS(REQS), .IDX_W(IDX_W)) u_pick (
    .clk(reg_clk), .rst(reset_reg), .req(req_valid), .upd(issue), .last(win), .pick(pick), .any(any)
  );
  assign issue = state == ISSUE;
  assign bad = int'(bank) >= BANKS;
  assign go = issue && !bad;
  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      state <= IDLE;
      win <= '0;
      wr <= 1'b0;
      bank <= '0;
      adr <= '0;
      wdata <= '0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && any) begin
        win <= pick;
        wr <= req_write[pick];
        bank <= req_bank[int'(pick)*BANK_W +: BANK_W];
        adr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
        wdata <= req_wdata[int'(pick)*DATA_W +: DATA_W];
      end
      if (issue) cnt <= CNT_W'(RD_LAT - 1);
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) rdata <= bus_rdata;
      end
    end
  end
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = any ? ISSUE : IDLE;
      ISSUE:   next = bad ? RESP : (wr ? IDLE : WAIT);
      WAIT:    next = (cnt == '0) ? RESP : WAIT;
      default: next = IDLE;
    endcase
  end
  // Out-of-range banks never reach the bus; they only produce an error response.
  assign req_ack   = issue ? REQS'(32'd1 << win) : '0;
  assign rsp_valid = (state == RESP) ? REQS'(32'd1 << win) : '0;
  assign rsp_err   = state == RESP && bad;
  assign rsp_rdata = (state == RESP && !bad) ? rdata : '0;
  assign bus_sel   = go ? BANKS'(bank_onehot(32'(bank))) : '0;
  assign bus_adr   = go ? adr : '0;
  assign bus_wdata = go ? wdata : '0;
  assign bus_write = go && wr;
  assign bus_read  = go && !wr;
endmodule

// File: tb/tb_param_bus_arbiter.sv
// tb_param_bus_arbiter: scoreboard bench for param_bus_arbiter with REQS=3, BANKS=6, RD_LAT=2.
module tb_param_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req_valid, req_write, req_ack, rsp_valid;
  logic [8:0] req_bank;
  logic [20:0] req_addr;
  logic [23:0] req_wdata;
  logic rsp_err, bus_write, bus_read;
  logic [7:0] rsp_rdata, bus_wdata, bus_rdata;
  logic [5:0] bus_sel;
  logic [6:0] bus_adr;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct { int cyc; logic [2:0] ack; logic [5:0] sel; logic [6:0] adr; logic [7:0] wd; logic wr; logic rd; } ack_t;
  typedef struct { int cyc; logic [2:0] v; logic err; logic [7:0] d; } rsp_t;
  ack_t ack_q[$];
  rsp_t rsp_q[$];
  ack_t ea;
  rsp_t er;
  logic [7:0] d1 = 8'hEE;
  logic [7:0] d2 = 8'hEE;
  int ord [4];
  logic [5:0] sel_t [3] = '{6'b000001, 6'b000010, 6'b001000};
  logic [6:0] adr_t [3] = '{7'h03, 7'h20, 7'h7F};
  logic [7:0] dat_t [3] = '{8'h3C, 8'h2F, 8'h70};
  param_bus_arbiter #(.REQS(3), .ADDR_W(7), .DATA_W(8), .BANKS(6), .RD_LAT(2)) dut (
    .reg_clk(clk), .reset_reg(rst), .req_valid(req_valid), .req_write(req_write), .req_bank(req_bank),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .bus_sel(bus_sel), .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_read(bus_read), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] bank_model(input logic [5:0] sel, input logic [6:0] adr);
    int b;
    b = 0;
    for (int i = 0; i < 6; i++) if (sel[i]) b = i;
    return ({1'b0, adr} ^ 8'h3F) + 8'(b * 16);
  endfunction
  // Bank with a two-stage read pipe: data is valid only in the second cycle after the strobe.
  always @(posedge clk) begin
    d1 <= bus_read ? bank_model(bus_sel, bus_adr) : 8'hEE;
    d2 <= d1;
  end
  assign bus_rdata = d2;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    if (req_ack != 3'b000) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 64'(req_ack), 64'd0);
      else begin
        ea = ack_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(ea.cyc));
        chk("ack_onehot", 64'(req_ack), 64'(ea.ack));
        chk("bus_sel_strobes", 64'({bus_sel, bus_write, bus_read}), 64'({ea.sel, ea.wr, ea.rd}));
        if (ea.sel != 6'd0) chk("bus_adr_wdata", 64'({bus_adr, bus_wdata}), 64'({ea.adr, ea.wd}));
      end
    end else chk("bus_idle", 64'({bus_sel, bus_write, bus_read}), 64'd0);
    if (rsp_valid != 3'b000) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      else begin
        er = rsp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(er.cyc));
        chk("rsp_valid_err_rdata", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({er.v, er.err, er.d}));
      end
    end
  end
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic put(input int m, input logic w, input logic [2:0] b, input logic [6:0] a, input logic [7:0] d);
    req_valid[m] = 1'b1;
    req_write[m] = w;
    req_bank[m*3 +: 3] = b;
    req_addr[m*7 +: 7] = a;
    req_wdata[m*8 +: 8] = d;
  endtask
  initial begin
    int n;
`ifdef PARAM_ARB_RR_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{0, 0, 0, 0};
`endif
    req_valid = '0;
    req_write = '0;
    req_bank = '0;
    req_addr = '0;
    req_wdata = '0;
    tick(3);
    chk("reset_outputs", 64'({req_ack, rsp_valid, rsp_err, rsp_rdata, bus_sel, bus_adr, bus_wdata, bus_write, bus_read}), 64'd0);
    rst = 1'b0;
    tick(2);
    n = cyc;
    put(1, 1'b1, 3'd2, 7'h15, 8'hA5);
    ack_q.push_back('{n + 1, 3'b010, 6'b000100, 7'h15, 8'hA5, 1'b1, 1'b0});
    tick();
    req_valid = '0;
    tick(4);
    n = cyc;
    put(0, 1'b0, 3'd0, 7'h03, 8'h00);
    ack_q.push_back('{n + 1, 3'b001, 6'b000001, 7'h03, 8'h00, 1'b0, 1'b1});
    rsp_q.push_back('{n + 4, 3'b001, 1'b0, 8'h3C});
    tick();
    req_valid = '0;
    tick(6);
    n = cyc;
    put(2, 1'b0, 3'd5, 7'h10, 8'h00);
    ack_q.push_back('{n + 1, 3'b100, 6'b100000, 7'h10, 8'h00, 1'b0, 1'b1});
    rsp_q.push_back('{n + 4, 3'b100, 1'b0, 8'h7F});
    tick();
    req_valid = '0;
    tick(6);
    n = cyc;
    put(2, 1'b0, 3'd7, 7'h11, 8'h00);
    ack_q.push_back('{n + 1, 3'b100, 6'b000000, 7'h00, 8'h00, 1'b0, 1'b0});
    rsp_q.push_back('{n + 2, 3'b100, 1'b1, 8'h00});
    tick();
    req_valid = '0;
    tick(5);
    n = cyc;
    put(1, 1'b1, 3'd6, 7'h22, 8'h5A);
    ack_q.push_back('{n + 1, 3'b010, 6'b000000, 7'h00, 8'h00, 1'b0, 1'b0});
    rsp_q.push_back('{n + 2, 3'b010, 1'b1, 8'h00});
    tick();
    req_valid = '0;
    tick(5);
    n = cyc;
    put(1, 1'b0, 3'd1, 7'h20, 8'h00);
    ack_q.push_back('{n + 1, 3'b010, 6'b000010, 7'h20, 8'h00, 1'b0, 1'b1});
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_outputs", 64'({req_ack, rsp_valid, rsp_err, rsp_rdata, bus_sel, bus_adr, bus_wdata, bus_write, bus_read}), 64'd0);
    rst = 1'b0;
    tick(6);
    n = cyc;
    put(0, 1'b0, 3'd0, 7'h03, 8'h00);
    put(1, 1'b0, 3'd1, 7'h20, 8'h00);
    put(2, 1'b0, 3'd3, 7'h7F, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ack_q.push_back('{n + 1 + 5*i, 3'(1 << ord[i]), sel_t[ord[i]], adr_t[ord[i]], 8'h00, 1'b0, 1'b1});
      rsp_q.push_back('{n + 4 + 5*i, 3'(1 << ord[i]), 1'b0, dat_t[ord[i]]});
    end
    tick(16);
    req_valid = '0;
    for (int i = 0; i < 40 && (ack_q.size() != 0 || rsp_q.size() != 0); i++) tick();
    tick(4);
    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
